// File: rtl/pl_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register word offsets, STATUS/CTRL bit positions, the
// transmit FSM state encoding and a helper for the effective bit period.
package pl_uart_pkg;

  // Register word offsets (address bits [3:2]).
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS bit positions; the FIFO count field starts at STAT_CNT_LSB.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // CTRL bit positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero would give a zero-length bit; treat it as one cycle.
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/pl_sync_fifo.sv
// Synchronous FIFO with combinational head-of-queue output.
// Ports:
//   clk      system clock, rising edge
//   clr_i    asynchronous reset, active-high (empties the FIFO)
//   push_i   write din_i at the clock edge (ignored when full)
//   din_i    write data
//   pop_i    drop the head entry at the clock edge (ignored when empty)
//   dout_o   head entry, valid whenever empty_o is low
//   full_o / empty_o / count_o  occupancy, all from pre-edge state
module pl_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Full/empty are pre-edge, so a pop in the same cycle never admits a
  // push into a full FIFO.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage needs no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge clr_i) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pl_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the MEM-stage data bus.
// Stores to TXDATA queue bytes in a FIFO; a baud-timed serialiser drains it.
// Ports:
//   clk    system clock, rising edge
//   clr    asynchronous reset, active-high
//   sel    address decode hit for this block's 16-byte window
//   we     store strobe, qualified by sel
//   addr   word offset (address bits [3:2])
//   wdata  store data
//   rdata  load data, combinational from addr and register state
//   txd    serial output, idles high
//   irq    transmit-done interrupt (level, registered)
module pl_uart_tx_mmio
  import pl_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RST    = 16'd434
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] divisor_q, divisor_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;

  logic          wr_en, push_req, fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   reload;
  logic          unused_wdata;

  assign wr_en        = sel & we;
  assign push_req     = wr_en & (addr == REG_TXDATA);
  assign reload       = bit_period(divisor_q) - 16'd1;
  assign unused_wdata = ^wdata[31:16];

  pl_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .clr_i   (clr),
    .push_i  (push_req),
    .din_i   (wdata[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register file next state.
  always_comb begin
    divisor_d = divisor_q;
    ctrl_d    = ctrl_q;
    ovf_d     = ovf_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if (wr_en) begin
      case (addr)
        REG_STATUS:  if (wdata[STAT_OVF]) ovf_d = 1'b0;
        REG_DIVISOR: divisor_d = wdata[15:0];
        REG_CTRL:    ctrl_d = wdata[1:0];
        default:     ;
      endcase
    end
    irq_d = ctrl_q[CTRL_IRQ_EN] & fifo_empty & (state_q == ST_IDLE);
  end

  // Transmit FSM. The baud counter is loaded with period-1 at every bit
  // start and the bit ends on the cycle it reads zero, so a DIVISOR write
  // only takes effect at the next bit boundary.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN] && !fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          bit_cnt_d = 3'd0;
          baud_d    = reload;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == 16'd0) begin
          baud_d  = reload;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = reload;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      baud_q    <= '0;
      divisor_q <= DIV_RST;
      ctrl_q    <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      divisor_q <= divisor_d;
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  // txd is decoded from state so reset forces the line high immediately.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      ST_START: txd = 1'b0;
      ST_DATA:  txd = shift_q[0];
      default:  txd = 1'b1;
    endcase
  end

  assign irq = irq_q;

  always_comb begin
    rdata = '0;
    case (addr)
      REG_STATUS: begin
        rdata[STAT_BUSY]             = (state_q != ST_IDLE);
        rdata[STAT_FULL]             = fifo_full;
        rdata[STAT_EMPTY]            = fifo_empty;
        rdata[STAT_OVF]              = ovf_q;
        rdata[STAT_CNT_LSB +: CW]    = fifo_count;
      end
      REG_DIVISOR: rdata[15:0] = divisor_q;
      REG_CTRL:    rdata[1:0]  = ctrl_q;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pl_uart_tx_mmio.sv
// Scoreboard bench: stimulus queues expected frames, a monitor decodes txd.
module tb_pl_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        txd;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Bit index 0 = start, 1..8 = data, 9 = stop; bits below sw use per_a.
  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] per_a;
    logic [15:0] per_b;
    logic [3:0]  sw;
    logic        chk_gap;
    logic [7:0]  gap;
    logic        abortable;
  } frame_t;

  frame_t exp_q[$];
  bit     mon_busy = 1'b0;

  always #5 clk = ~clk;

  pl_uart_tx_mmio #(
    .FIFO_DEPTH (8),
    .DIV_RST    (16'd434)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd),
    .irq   (irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end else begin
      $display("ok   %s: 0x%08h", name, got);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
    $display("wr   addr=%0d data=0x%08h", a, d);
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] want);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    check(name, rdata, want);
    sel = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int pa, input int pb,
                              input int sw, input int gap, input bit ab);
    frame_t f;
    f.data      = d;
    f.per_a     = pa[15:0];
    f.per_b     = pb[15:0];
    f.sw        = sw[3:0];
    f.chk_gap   = (gap >= 0);
    f.gap       = gap[7:0];
    f.abortable = ab;
    exp_q.push_back(f);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout with %0d frames pending, want 0", name, exp_q.size());
    end else begin
      $display("ok   %s: frames drained after %0d cycles", name, n);
    end
  endtask

  // Monitor: samples txd once per cycle on the falling edge.
  initial begin : monitor
    int     idle_run = 0;
    frame_t e;
    int     bad, p, first_bad;
    bit     aborted;
    logic   lvl;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (clr) begin
        idle_run = 0;
      end else if (txd === 1'b1) begin
        idle_run++;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got start bit, want idle line");
        for (int k = 0; k < 5000; k++) begin
          if (txd === 1'b1 || clr) break;
          @(negedge clk);
        end
        idle_run = 0;
      end else begin
        e = exp_q.pop_front();
        mon_busy = 1'b1;
        bad = 0; first_bad = -1; aborted = 1'b0; rx = 8'h00;
        if (e.chk_gap) begin
          checks++;
          if (idle_run != int'(e.gap)) begin
            errors++;
            $display("FAIL frame_gap %02h: got %0d idle cycles want %0d", e.data, idle_run, e.gap);
          end
        end
        for (int b = 0; b < 10 && !aborted; b++) begin
          lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
          p = (b < int'(e.sw)) ? int'(e.per_a) : int'(e.per_b);
          for (int c = 0; c < p; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (clr) begin
              aborted = 1'b1;
              break;
            end
            if (b >= 1 && b <= 8 && c == p / 2) rx[b-1] = txd;
            if (txd !== lvl) begin
              bad++;
              if (first_bad < 0) first_bad = b;
            end
          end
        end
        if (aborted) begin
          if (!e.abortable) begin
            checks++;
            errors++;
            $display("FAIL frame_abort %02h: got reset mid-frame want complete frame", e.data);
          end else begin
            $display("frm  %02h cut short by reset", e.data);
          end
        end else begin
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL frame %02h: got byte %02h with %0d bad samples (first at bit %0d) want clean frame",
                     e.data, rx, bad, first_bad);
          end else begin
            $display("frm  %02h received", rx);
          end
        end
        idle_run = 0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    read_check("rst_status", 2'd1, 32'h004);
    read_check("rst_divisor", 2'd2, 32'd434);
    read_check("rst_ctrl", 2'd3, 32'd0);
    read_check("rst_txdata", 2'd0, 32'd0);
    clr = 1'b0;

    // Basic frame, DIVISOR=4, byte 0x55.
    write_reg(2'd2, 32'd4);
    write_reg(2'd3, 32'd1);
    read_check("divisor4", 2'd2, 32'd4);
    expect_frame(8'h55, 4, 4, 10, -1, 1'b0);
    write_reg(2'd0, 32'h55);
    check("lat_pre_txd", {31'd0, txd}, 32'd1);
    read_check("lat_pre_status", 2'd1, 32'h010);
    @(posedge clk); #1;
    check("lat_start_txd", {31'd0, txd}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      repeat (5) @(posedge clk); #1;
      read_check("busy_during_frame", 2'd1, 32'h005);
    end
    wait_done("frame55", 200);
    repeat (2) @(posedge clk); #1;
    read_check("status_after_55", 2'd1, 32'h004);

    // Overflow: fill with enable off, ninth byte dropped.
    write_reg(2'd3, 32'd0);
    for (int i = 1; i <= 9; i++) write_reg(2'd0, i);
    read_check("status_full_ovf", 2'd1, 32'h08A);
    for (int i = 1; i <= 8; i++) expect_frame(i[7:0], 4, 4, 10, (i == 1) ? -1 : 1, 1'b0);
    write_reg(2'd3, 32'd1);
    wait_done("drain8", 2000);
    repeat (2) @(posedge clk); #1;
    read_check("status_drained_ovf", 2'd1, 32'h00C);
    write_reg(2'd1, 32'h8);
    read_check("status_ovf_cleared", 2'd1, 32'h004);

    // DIVISOR=0 behaves as one cycle per bit.
    write_reg(2'd2, 32'd0);
    read_check("divisor0", 2'd2, 32'd0);
    expect_frame(8'hA3, 1, 1, 10, -1, 1'b0);
    write_reg(2'd0, 32'hA3);
    wait_done("frameA3", 100);

    // Interrupt timing.
    write_reg(2'd2, 32'd2);
    expect_frame(8'hFF, 2, 2, 10, -1, 1'b0);
    write_reg(2'd0, 32'hFF);
    write_reg(2'd3, 32'd3);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      check("irq_timing", {31'd0, irq}, (i >= 20) ? 32'd1 : 32'd0);
    end
    write_reg(2'd3, 32'd1);
    check("irq_hold_one_cycle", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wait_done("frameFF", 50);

    // Mid-frame DIVISOR change: bit 3 keeps 8 cycles, later bits use 2.
    write_reg(2'd2, 32'd8);
    expect_frame(8'h35, 8, 2, 5, -1, 1'b0);
    write_reg(2'd0, 32'h35);
    repeat (34) @(posedge clk);
    write_reg(2'd2, 32'd2);
    wait_done("frame35_divchange", 300);

    // Reset in the middle of DATA with bytes still queued.
    write_reg(2'd2, 32'd4);
    expect_frame(8'h11, 4, 4, 10, -1, 1'b1);
    write_reg(2'd0, 32'h11);
    write_reg(2'd0, 32'h22);
    write_reg(2'd0, 32'h33);
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_txd_in_frame", {31'd0, mon_busy}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    check("reset_txd_high", {31'd0, txd}, 32'd1);
    check("reset_irq_low", {31'd0, irq}, 32'd0);
    read_check("reset_status", 2'd1, 32'h004);
    read_check("reset_divisor", 2'd2, 32'd434);
    read_check("reset_ctrl", 2'd3, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    read_check("post_reset_status", 2'd1, 32'h004);
    write_reg(2'd3, 32'd1);
    repeat (60) @(posedge clk); #1;
    check("post_reset_idle_txd", {31'd0, txd}, 32'd1);
    check("post_reset_no_pending", exp_q.size(), 32'd0);
    read_check("post_reset_status_final", 2'd1, 32'h004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_uart_tx_mmio.md
Name: pl_uart_tx_mmio

Overview:
- Memory-mapped UART transmitter. It is the responder on the CPU's MEM-stage data-memory interface: write enable, address from the ALU result, store data in, load data out.
- CPU stores push bytes into a TX FIFO. A baud-timed 8N1 serialiser drains the FIFO onto txd.
- It sits beside data memory. Top-level address decode drives sel, and the top-level mux selects rdata onto the MEM-stage load result when sel is high.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, range 2..16.
- DIV_RST, 16'd434, reset value of the DIVISOR register (bit period in clk cycles).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous reset, active-high.
- sel  in  1  address decode hit for this block's 16-byte window.
- we  in  1  store strobe; qualified by sel.
- addr  in  2  word offset (address bits [3:2]).
- wdata  in  32  store data.
- rdata  out  32  load data; combinational from addr.
- txd  out  1  serial output; idles high.
- irq  out  1  transmit-done interrupt, level.

Behaviour:
- Reset (async, clr=1): txd=1, irq=0, FIFO empty, FSM=IDLE, DIVISOR=DIV_RST, CTRL=0, overflow=0. rdata reflects the reset register values.
- Register map, by addr:
  - 0 TXDATA. W: push wdata[7:0]. R: 0.
  - 1 STATUS. R: bit0 busy (FSM!=IDLE), bit1 full, bit2 empty, bit3 overflow, bits[8:4] count. W: writing 1 to bit3 clears overflow. Other bits read 0.
  - 2 DIVISOR. RW, bits[15:0]. Upper bits read 0.
  - 3 CTRL. RW. bit0 enable, bit1 irq_en.
- Writes happen at the clk edge when sel&we. Reads are a pure function of register state.
- Push when FIFO is full: the byte is dropped and overflow sets. The full test uses the pre-edge count, so a same-cycle pop does not admit the byte. Overflow is sticky until cleared.
- Simultaneous push (not full) and pop: count is unchanged, data order is preserved.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if enable & !empty, pop the head into the shift register, load the bit counter, go to START.
  - START: txd=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, then STOP.
  - STOP: txd=1 for one bit period, then IDLE.
- Bit period is max(DIVISOR,1) cycles. The baud counter reloads from DIVISOR at each bit start, so a mid-frame DIVISOR write affects only later bits.
- Latency: a push at edge k is followed by a pop and txd=0 after edge k+1, given enable=1 and an idle FSM.
- Back-to-back frames: IDLE lasts exactly 1 cycle between the stop bit and the next start bit.
- Clearing enable mid-frame lets the current frame finish; no further pops occur.
- irq = irq_en & empty & (FSM==IDLE), registered, 1 cycle after the condition holds.
- Reset mid-frame: txd goes high immediately, the remaining frame and all FIFO contents are discarded.
- count width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package pl_uart_pkg holds:
  - register offsets: TXDATA=0, STATUS=1, DIVISOR=2, CTRL=3.
  - STATUS bit positions.
  - the FSM state encoding: 2-bit IDLE/START/DATA/STOP.
- One sub-module: pl_sync_fifo, a parameterised depth/width FIFO.
  - push/pop inputs; full/empty/count outputs; head data visible combinationally.
  - Instantiated with width 8.
- The register file, baud counter and FSM stay in pl_uart_tx_mmio.

Test Plan:
- DIVISOR=4, CTRL=1, write TXDATA=0x55 -> txd low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4; frame = 40 cycles. STATUS.busy=1 throughout; STATUS=0x004 (empty, idle) afterwards.
- CTRL=0, write 9 bytes 0x01..0x09 -> STATUS count=8, full=1, overflow=1. Then CTRL=1 -> bytes 0x01..0x08 transmit in order with 1 idle cycle between frames; 0x09 never appears. Write STATUS=0x8 -> overflow=0.
- DIVISOR=0, push 0xA3 -> 1 cycle per bit, frame = 10 cycles, bits 1,1,0,0,0,1,0,1.
- CTRL=3, push 0xFF with DIVISOR=2 -> irq=0 during the frame; irq=1 one cycle after the FSM returns to IDLE with FIFO empty. Writing CTRL=1 -> irq=0 next cycle.
- Assert clr for 1 cycle in the middle of DATA with 3 bytes queued:
  - txd=1 immediately.
  - STATUS=0x004.
  - DIVISOR reads 434.
  - No further output after reset releases.
- DIVISOR=8 frame in progress; write DIVISOR=2 during bit 3 -> bit 3 lasts 8 cycles, bits 4..7 and the stop bit last 2 cycles each.
